// File: rtl/bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl
//
// Multi-digit packed-BCD adder built around one single-digit BCD add stage.
// On an accepted start the operands and carry-in are captured and then walked
// least-significant digit first, one digit per clock, with the decimal carry
// rippling through a register. Completion is reported with a one-cycle done
// pulse; busy is high for the whole operation.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : operation request, sampled only while idle
//   a, b   : packed-BCD operands, digit i in bits [4i+3:4i]
//   cin    : decimal carry into digit 0
//   busy   : high whenever an operation is in progress (RUN or DONE)
//   done   : one-cycle completion pulse
//   sum    : packed-BCD result, valid from done until the next accepted start
//   cout   : decimal carry out of the top digit
//   err    : an operand digit was greater than 9 at capture
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    // Digit index width; a one-digit adder still gets a 1-bit index.
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when any 4-bit digit of the packed vector is outside 0..9.
    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    // Single-digit BCD add: returns {carry_out, digit}. A binary total above 9
    // is corrected by adding 6, which wraps the low nibble into 0..9.
    function automatic logic [4:0] bcd_digit_add(
        input logic [3:0] ad,
        input logic [3:0] bd,
        input logic       c
    );
        logic [4:0] t;
        logic [4:0] t_adj;
        logic [4:0] res;
        t     = {1'b0, ad} + {1'b0, bd} + {4'b0000, c};
        t_adj = t + 5'd6;
        if (t > 5'd9) begin
            res = {1'b1, t_adj[3:0]};
        end else begin
            res = {1'b0, t[3:0]};
        end
        return res;
    endfunction

    state_t                 state_q,  state_d;
    logic [4*DIGITS-1:0]    a_q,      a_d;
    logic [4*DIGITS-1:0]    b_q,      b_d;
    logic                   carry_q,  carry_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;
    logic [4*DIGITS-1:0]    sum_q,    sum_d;
    logic                   cout_q,   cout_d;
    logic                   err_q,    err_d;
    logic                   busy_q,   busy_d;
    logic                   done_q,   done_d;

    logic [3:0]             a_dig_s;
    logic [3:0]             b_dig_s;
    logic [4:0]             add_s;

    // Select the current digit of each captured operand and add it.
    always_comb begin
        a_dig_s = 4'd0;
        b_dig_s = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            a_dig_s = (idx_q == IDX_W'(i)) ? a_q[4*i +: 4] : a_dig_s;
            b_dig_s = (idx_q == IDX_W'(i)) ? b_q[4*i +: 4] : b_dig_s;
        end
        add_s = bcd_digit_add(a_dig_s, b_dig_s, carry_q);
    end

    // Next-state and next-output logic for the digit sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    // Illegal digits skip the walk entirely and report at once.
                    if (has_bad_digit(a) || has_bad_digit(b)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    sum_d[4*i +: 4] = (idx_q == IDX_W'(i)) ? add_s[3:0] : sum_q[4*i +: 4];
                end
                carry_d = add_s[4];
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_s[4];
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the upcoming state.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for bcd_serial_add_ctrl (DIGITS = 4).
// A behavioural model converts BCD operands to integers, adds them and
// converts back; it tracks only how many busy cycles remain. One compare
// process checks the DUT against it every cycle, and directed operations pin
// the model with hand-computed results.
// ---------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int n_dones  = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pow10();
        int p = 1;
        for (int i = 0; i < DIGITS; i++) p = p * 10;
        return p;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int n);
        logic [W-1:0] r = '0;
        int x = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Decimal addition in plain integers: returns {carry, packed-BCD sum}.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int t;
        int p;
        p = pow10();
        t = bcd_to_int(x) + bcd_to_int(y) + int'(c);
        return {(t >= p) ? 1'b1 : 1'b0, int_to_bcd(t % p)};
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 15) == 0) r[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    // m_left = busy cycles still to come (1 means the done cycle).
    int           m_left;
    logic [W-1:0] m_sum, m_fsum;
    logic         m_cout, m_fcout, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_sum   <= '0;
            m_fsum  <= '0;
            m_cout  <= 1'b0;
            m_fcout <= 1'b0;
            m_err   <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_sum  <= m_fsum;
                m_cout <= m_fcout;
            end
        end else if (start === 1'b1) begin
            m_sum  <= '0;
            m_cout <= 1'b0;
            if (!bcd_ok(a) || !bcd_ok(b)) begin
                m_err   <= 1'b1;
                m_left  <= 1;
                m_fsum  <= '0;
                m_fcout <= 1'b0;
            end else begin
                m_err   <= 1'b0;
                m_left  <= DIGITS + 1;
                {m_fcout, m_fsum} <= ref_add(a, b, cin);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("done", 32'(done), 32'(m_left == 1));
            chk("err",  32'(err),  32'(m_err));
            chk("cout", 32'(cout), 32'(m_cout));
            if (m_left <= 1) chk("sum", 32'(sum), 32'(m_sum));
            if (done === 1'b1) n_dones++;
        end
    end

    // One operation with a single-cycle start; checks latency and results.
    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic [W-1:0] exp_sum, input logic exp_cout,
                          input logic exp_err, input int exp_lat);
        int lat;
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_sum"},     32'(sum), 32'(exp_sum));
        chk({name, "_cout"},    32'(cout), 32'(exp_cout));
        chk({name, "_err"},     32'(err), 32'(exp_err));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_err",  32'(err),  32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_op("basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 5);
        run_op("ripple",   16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5);
        run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 5);
        run_op("max",      16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 5);
        run_op("fives",    16'h0505, 16'h0505, 1'b0, 16'h1010, 1'b0, 1'b0, 5);
        run_op("bad_dig",  16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
        run_op("err_clr",  16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 5);

        // Start held high through RUN and DONE with changing operands.
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h9999; b = 16'h9999;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("held_latency", 32'(lat), 32'd5);
        chk("held_sum1",    32'(sum), 32'h0003);
        @(negedge clk);
        chk("held_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("held_reaccept", 32'(busy), 32'd1);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("held2_latency", 32'(lat), 32'd5);
        chk("held2_sum",     32'(sum), 32'h9998);
        chk("held2_cout",    32'(cout), 32'd1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum",  32'(sum),  32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_err",  32'(err),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 16'h0046, 16'h0055, 1'b0, 16'h0101, 1'b0, 1'b0, 5);

        // Randomized traffic, checked cycle by cycle against the model.
        n_dones = 0;
        repeat (800) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a     = rand_bcd();
            b     = rand_bcd();
            cin   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("random_activity", 32'(n_dones > 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
